data_mem_stage: RTL and testbench
=================================

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: data memory depth in 32-bit words, power of two.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port MemReadM  in  1  load in M stage.
REQ-005 SHALL have port MemWriteM  in  1  store in M stage.
REQ-006 SHALL have port AccessSizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (no access).
REQ-007 SHALL have port IsUnsignedM  in  1  zero-extend flag for the load.
REQ-008 SHALL have port ALUOutM  in  32  byte address.
REQ-009 SHALL have port WriteDataM  in  32  store data, right-aligned.
REQ-010 SHALL have port StallW  in  1  hold W-stage registers.
REQ-011 SHALL have port FlushW  in  1  clear W-stage registers.
REQ-012 SHALL have port AddrErrM  out  1  combinational misaligned-access flag.
REQ-013 SHALL have port ReadDataW  out  32  registered raw memory word.
REQ-014 SHALL have port BEOutW  out  4  registered byte-lane enables of the load.
REQ-015 SHALL have port IsUnsignedW  out  1  registered IsUnsignedM.
REQ-016 SHALL have port AddrErrW  out  1  registered AddrErrM.

Function
REQ-017 SHALL form the lane mask combinationally as follows: byte access gives 4'b0001 shifted left by ALUOutM[1:0]; half access gives 0011 if ALUOutM[1]=0, else 1100; word access gives 1111; reserved size gives 0000.
REQ-018 SHALL flag AddrErrM=1 when (MemReadM|MemWriteM) and either half access with ALUOutM[0]=1 or word access with ALUOutM[1:0]!=00; the lane mask SHALL then be forced to 0000.
REQ-019 SHALL index memory by ALUOutM[log2(DEPTH_WORDS)+1:2] and ignore upper address bits, so addresses wrap modulo DEPTH_WORDS*4.
REQ-020 SHALL replicate store data onto the lanes: byte data on all four lanes, half data on both halves, word data unchanged.
REQ-021 SHALL write only the enabled lanes at the rising edge when MemWriteM=1 and the lane mask is nonzero; disabled lanes retain their contents.
REQ-022 SHALL ignore StallW for stores; a repeated identical store is idempotent.
REQ-023 SHALL load the W registers at each rising edge when StallW=0, with ReadDataW = full addressed word, BEOutW = lane mask if MemReadM=1 else 0000, IsUnsignedW = IsUnsignedM, and AddrErrW = AddrErrM.
REQ-024 SHALL give loads a latency of one cycle, with the M-stage address appearing as ReadDataW/BEOutW after the next edge.
REQ-025 SHALL make ReadDataW reflect memory contents before any same-edge write (read-before-write).
REQ-026 SHALL clear all W registers to 0 at the edge when FlushW=1; FlushW SHALL override StallW.
REQ-027 SHALL hold all W registers at the edge when StallW=1 and FlushW=0.
REQ-028 SHALL perform no access when MemReadM and MemWriteM are both 1; the lane mask SHALL be 0000 and AddrErrM=0.

Reset
REQ-029 SHALL, while rst_n=0, immediately drive ReadDataW=0, BEOutW=0000, IsUnsignedW=0 and AddrErrW=0, independent of clk.
REQ-030 SHALL block memory writes while rst_n=0; memory contents SHALL NOT be reset and are undefined after power-up.
REQ-031 SHALL abort any in-flight load on reset assertion mid-operation; the first post-reset edge behaves per REQ-023.

Configuration
REQ-032 SHALL, with DM_ADDR_ERR_EN defined, implement the misalignment detection and suppression of REQ-018.
REQ-033 SHALL, with DM_ADDR_ERR_EN undefined, tie AddrErrM and AddrErrW to 0, ignore ALUOutM[0] for half access and ALUOutM[1:0] for word access (forced alignment), and accept every access.

Verification
REQ-034 SHALL cover: store word 0x11223344 at 0x10, then load word at 0x10 -> next cycle ReadDataW=0x11223344, BEOutW=1111.
REQ-035 SHALL cover: after REQ-034, store byte 0xAB at 0x13, then unsigned byte load at 0x13 -> ReadDataW=0xAB223344, BEOutW=1000, IsUnsignedW=1.
REQ-036 SHALL cover: store half 0xBEEF at 0x11 with DM_ADDR_ERR_EN -> AddrErrM=1, word at 0x10 unchanged, AddrErrW=1 next cycle; without the macro -> word becomes 0xAB22BEEF.
REQ-037 SHALL cover: load at 0x10 with StallW=1 -> W registers hold their prior values; FlushW=1 with StallW=1 -> all W outputs become 0.
REQ-038 SHALL cover: DEPTH_WORDS=1024 and a load at 0x1010 -> same data as 0x10; rst_n low mid-load -> outputs 0 before the next clk edge.

Source files
------------

// File: rtl/data_mem_stage.sv
// M-stage byte-lane data memory feeding the W-stage load registers.
// Define DM_ADDR_ERR_EN to flag and suppress misaligned half/word accesses.
module data_mem_stage #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [1:0]  AccessSizeM,
   input  logic        IsUnsignedM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic        StallW,
   input  logic        FlushW,
   output logic        AddrErrM,
   output logic [31:0] ReadDataW,
   output logic [3:0]  BEOutW,
   output logic        IsUnsignedW,
   output logic        AddrErrW
);

   localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DM_ADDR_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic          access;
   logic          misalign;
   logic [3:0]    lanes;
   logic [3:0]    mask;
   logic [31:0]   wdata;
   logic          unused_addr;

   assign idx         = ALUOutM[AW+1:2];
   assign unused_addr = ^ALUOutM[31:AW+2];

   // A simultaneous load and store is treated as no access at all.
   assign access = MemReadM ^ MemWriteM;

   always_comb begin
      lanes    = 4'b0000;
      wdata    = WriteDataM;
      misalign = 1'b0;
      unique case (AccessSizeM)
         2'b00: begin
            lanes = 4'b0001 << ALUOutM[1:0];
            wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            lanes    = ALUOutM[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{WriteDataM[15:0]}};
            misalign = ALUOutM[0];
         end
         2'b10: begin
            lanes    = 4'b1111;
            misalign = |ALUOutM[1:0];
         end
         default: ;
      endcase
   end

   assign AddrErrM = ErrEn & access & misalign;
   assign mask     = (access && !AddrErrM) ? lanes : 4'b0000;

   always_ff @(posedge clk) begin
      if (rst_n && MemWriteM) begin
         for (int i = 0; i < 4; i++) begin
            if (mask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ReadDataW   <= '0;
         BEOutW      <= '0;
         IsUnsignedW <= 1'b0;
         AddrErrW    <= 1'b0;
      end else if (FlushW) begin
         ReadDataW   <= '0;
         BEOutW      <= '0;
         IsUnsignedW <= 1'b0;
         AddrErrW    <= 1'b0;
      end else if (!StallW) begin
         ReadDataW   <= mem[idx];
         BEOutW      <= MemReadM ? mask : 4'b0000;
         IsUnsignedW <= IsUnsignedM;
         AddrErrW    <= AddrErrM;
      end
   end

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: directed vector table, hand sequences,
// then random traffic against a byte-lane reference model.
module tb_data_mem_stage;

`ifdef DM_ADDR_ERR_EN
   localparam bit E = 1'b1;
`else
   localparam bit E = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemReadM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [1:0]  AccessSizeM = 2'b00;
   logic        IsUnsignedM = 1'b0;
   logic [31:0] ALUOutM = '0;
   logic [31:0] WriteDataM = '0;
   logic        StallW = 1'b0;
   logic        FlushW = 1'b0;
   logic        AddrErrM;
   logic [31:0] ReadDataW;
   logic [3:0]  BEOutW;
   logic        IsUnsignedW;
   logic        AddrErrW;

   data_mem_stage #(.DEPTH_WORDS(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .AccessSizeM(AccessSizeM), .IsUnsignedM(IsUnsignedM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .StallW(StallW), .FlushW(FlushW),
      .AddrErrM(AddrErrM), .ReadDataW(ReadDataW),
      .BEOutW(BEOutW), .IsUnsignedW(IsUnsignedW),
      .AddrErrW(AddrErrW)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic        cd;
      logic [31:0] rdat;
      logic [3:0]  be;
   } vec_t;

   vec_t tv[14];

   logic [31:0] m_mem [1024];
   bit          m_val [1024];
   logic [31:0] w_rd;
   bit          w_rv;
   logic [3:0]  w_be;
   logic        w_uns;
   logic        w_err;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic st, input logic fl);
      MemReadM    = rd;
      MemWriteM   = wr;
      AccessSizeM = sz;
      IsUnsignedM = uns;
      ALUOutM     = a;
      WriteDataM  = wd;
      StallW      = st;
      FlushW      = fl;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_w(input string nm, input logic [31:0] d,
                        input logic [3:0] be, input logic uns,
                        input logic er);
      chk({nm, ".data"}, ReadDataW, d);
      chk({nm, ".be"}, 32'(BEOutW), 32'(be));
      chk({nm, ".uns"}, 32'(IsUnsignedW), 32'(uns));
      chk({nm, ".errw"}, 32'(AddrErrW), 32'(er));
   endtask

   function automatic vec_t vec(input logic rd, input logic wr,
                                input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic er, input logic cd,
                                input logic [31:0] rdat,
                                input logic [3:0] be);
      vec_t v;
      v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns;
      v.addr = a; v.wd = wd; v.err = er; v.cd = cd;
      v.rdat = rdat; v.be = be;
      return v;
   endfunction

   // Reference: an access of n bytes covers n lanes starting at the
   // address rounded down to n; misalignment only matters when enabled.
   function automatic logic m_err(input logic rd, input logic wr,
                                  input logic [1:0] sz,
                                  input logic [31:0] a);
      int n;
      if (!(rd ^ wr) || sz == 2'd3 || sz == 2'd0) return 1'b0;
      n = 1 << sz;
      return E && (int'(a[1:0]) % n != 0);
   endfunction

   function automatic logic [3:0] m_mask(input logic rd, input logic wr,
                                         input logic [1:0] sz,
                                         input logic [31:0] a);
      int n;
      int base;
      int m;
      if (!(rd ^ wr) || sz == 2'd3) return 4'b0000;
      if (m_err(rd, wr, sz, a)) return 4'b0000;
      n = 1 << sz;
      base = (int'(a[1:0]) / n) * n;
      m = ((1 << n) - 1) << base;
      return m[3:0];
   endfunction

   task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic st, input logic fl);
      logic [3:0] mk;
      logic       er;
      int         n;
      int         ix;
      set_in(rd, wr, sz, uns, a, wd, st, fl);
      #1;
      er = m_err(rd, wr, sz, a);
      mk = m_mask(rd, wr, sz, a);
      chk("rnd.addr_err_m", 32'(AddrErrM), 32'(er));
      ix = int'(a[11:2]);
      if (fl) begin
         w_rd = '0; w_rv = 1'b1; w_be = '0; w_uns = 1'b0; w_err = 1'b0;
      end else if (!st) begin
         w_rd = m_mem[ix]; w_rv = m_val[ix];
         w_be = rd ? mk : 4'b0000; w_uns = uns; w_err = er;
      end
      if (wr && mk != 4'b0000) begin
         n = 1 << sz;
         for (int i = 0; i < 4; i++)
            if (mk[i]) m_mem[ix][8*i +: 8] = wd[8*(i % n) +: 8];
         if (mk == 4'hF) m_val[ix] = 1'b1;
      end
      edge1();
      if (w_rv) chk("rnd.data", ReadDataW, w_rd);
      chk("rnd.be", 32'(BEOutW), 32'(w_be));
      chk("rnd.uns", 32'(IsUnsignedW), 32'(w_uns));
      chk("rnd.errw", 32'(AddrErrW), 32'(w_err));
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] r;
      d = E ? 32'hAB22_3344 : 32'hAB22_BEEF;
      tv[0]  = vec(0, 1, 2, 0, 32'h10, 32'h1122_3344, 0, 0, 0, 4'h0);
      tv[1]  = vec(1, 0, 2, 0, 32'h10, 0, 0, 1, 32'h1122_3344, 4'hF);
      tv[2]  = vec(0, 1, 0, 0, 32'h13, 32'hAB, 0, 1, 32'h1122_3344, 4'h0);
      tv[3]  = vec(1, 0, 0, 1, 32'h13, 0, 0, 1, 32'hAB22_3344, 4'h8);
      tv[4]  = vec(0, 1, 1, 0, 32'h11, 32'hBEEF, E, 1, 32'hAB22_3344, 4'h0);
      tv[5]  = vec(1, 0, 2, 0, 32'h10, 0, 0, 1, d, 4'hF);
      tv[6]  = vec(1, 0, 2, 1, 32'h1010, 0, 0, 1, d, 4'hF);
      tv[7]  = vec(1, 0, 1, 0, 32'h12, 0, 0, 1, d, 4'hC);
      tv[8]  = vec(1, 0, 1, 0, 32'h13, 0, E, 1, d, E ? 4'h0 : 4'hC);
      tv[9]  = vec(1, 0, 0, 1, 32'h11, 0, 0, 1, d, 4'h2);
      tv[10] = vec(1, 0, 3, 0, 32'h10, 0, 0, 1, d, 4'h0);
      tv[11] = vec(1, 1, 2, 0, 32'h11, 32'hDEAD_DEAD, 0, 1, d, 4'h0);
      tv[12] = vec(1, 0, 2, 0, 32'h10, 0, 0, 1, d, 4'hF);
      tv[13] = vec(1, 0, 2, 0, 32'h12, 0, E, 1, d, E ? 4'h0 : 4'hF);

      #1;
      chk_w("reset", 32'h0, 4'h0, 1'b0, 1'b0);
      edge1();
      edge1();
      @(negedge clk);
      rst_n = 1'b1;
      edge1();

      foreach (tv[k]) begin
         set_in(tv[k].rd, tv[k].wr, tv[k].sz, tv[k].uns,
                tv[k].addr, tv[k].wd, 1'b0, 1'b0);
         #1;
         chk($sformatf("vec%0d.errm", k), 32'(AddrErrM), 32'(tv[k].err));
         edge1();
         if (tv[k].cd) chk($sformatf("vec%0d.data", k), ReadDataW, tv[k].rdat);
         chk($sformatf("vec%0d.be", k), 32'(BEOutW), 32'(tv[k].be));
         chk($sformatf("vec%0d.uns", k), 32'(IsUnsignedW), 32'(tv[k].uns));
         chk($sformatf("vec%0d.errw", k), 32'(AddrErrW), 32'(tv[k].err));
      end

      set_in(1, 0, 2, 0, 32'h10, 0, 0, 0);
      edge1();
      set_in(1, 0, 0, 1, 32'h20, 0, 1, 0);
      edge1();
      chk_w("stall_hold", d, 4'hF, 1'b0, 1'b0);
      set_in(0, 1, 2, 1, 32'h20, 32'hCAFE_F00D, 1, 0);
      edge1();
      chk_w("stall_store", d, 4'hF, 1'b0, 1'b0);
      set_in(1, 0, 2, 1, 32'h20, 0, 1, 1);
      edge1();
      chk_w("flush", 32'h0, 4'h0, 1'b0, 1'b0);
      set_in(1, 0, 2, 0, 32'h20, 0, 0, 0);
      edge1();
      chk_w("store_under_stall", 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);

      set_in(1, 0, 2, 1, 32'h10, 0, 0, 0);
      edge1();
      chk_w("pre_reset", d, 4'hF, 1'b1, 1'b0);
      set_in(1, 0, 2, 1, 32'h20, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_w("async_reset", 32'h0, 4'h0, 1'b0, 1'b0);
      set_in(0, 1, 2, 0, 32'h10, 32'h5555_5555, 0, 0);
      edge1();
      chk_w("in_reset", 32'h0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1, 0, 2, 0, 32'h10, 0, 0, 0);
      edge1();
      chk_w("write_blocked", d, 4'hF, 1'b0, 1'b0);

      for (int i = 0; i < 1024; i++) m_val[i] = 1'b0;
      op(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         op(0, 1, 2, 0, 32'(i * 4), r, 0, 0);
      end
      for (int i = 0; i < 400; i++) begin
         logic [3:0] ix;
         logic [1:0] lo;
         r = $urandom;
         ix = 4'($urandom_range(0, 15));
         lo = 2'($urandom_range(0, 3));
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            {r[31:12], 6'b0, ix, lo}, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
